// File: rtl/counter_pkg.sv
// Shared mode constants for the counter family.
package counter_pkg;

   localparam int unsigned WRAP_MODE = 0;
   localparam int unsigned SAT_MODE  = 1;
   localparam int unsigned LEVEL_EN  = 0;
   localparam int unsigned EDGE_EN   = 1;

endpackage : counter_pkg

// File: rtl/edge_detect.sv
// Two-flop synchroniser plus rising-edge detector; Pulse is high for one Clk cycle per In rise.
module edge_detect (
   input  logic Clk,
   input  logic Clr,
   input  logic In,
   output logic Pulse
);

   logic sync1;
   logic sync2;
   logic hist;
   logic live1;
   logic live2;
   logic armed;

   // armed only rises once a genuine low has come through the synchroniser,
   // so an input already high when Clr drops cannot fake a rising edge.
   always_ff @(posedge Clk or posedge Clr) begin
      if (Clr) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         hist  <= 1'b0;
         live1 <= 1'b0;
         live2 <= 1'b0;
         armed <= 1'b0;
      end else begin
         sync1 <= In;
         sync2 <= sync1;
         hist  <= sync2;
         live1 <= 1'b1;
         live2 <= live1;
         if (live2 && !sync2) begin
            armed <= 1'b1;
         end
      end
   end

   assign Pulse = sync2 & ~hist & armed;

endmodule : edge_detect

// File: rtl/updown_counter.sv
// Loadable up/down counter over 0..MAX with wrap or saturate behaviour,
// a registered wrap pulse and a sticky overflow flag.
module updown_counter
   import counter_pkg::*;
#(
   parameter int unsigned     WIDTH    = 16,
   parameter longint unsigned MAX      = (64'd1 << WIDTH) - 64'd1,
   parameter int unsigned     SATURATE = WRAP_MODE,
   parameter int unsigned     EDGE     = LEVEL_EN
) (
   input  logic             Clk,
   input  logic             Clr,
   input  logic             En,
   input  logic             Up,
   input  logic             Load,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q,
   output logic             Tc,
   output logic             Wrap,
   output logic             Ovf
);

   localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX);

   logic             step;
   logic [WIDTH-1:0] q_nxt;
   logic             wrap_nxt;
   logic             ovf_nxt;

   if (EDGE == EDGE_EN) begin : g_edge
      edge_detect u_edge (
         .Clk   (Clk),
         .Clr   (Clr),
         .In    (En),
         .Pulse (step)
      );
   end else begin : g_level
      assign step = En;
   end

   // Next count: load beats step; range ends either wrap or hold.
   always_comb begin
      q_nxt    = Q;
      wrap_nxt = 1'b0;
      ovf_nxt  = Ovf;
      if (Load) begin
         q_nxt = (D > MAX_Q) ? MAX_Q : D;
      end else if (step) begin
         if (Up) begin
            if (Q == MAX_Q) begin
               ovf_nxt = 1'b1;
               if (SATURATE != SAT_MODE) begin
                  q_nxt    = '0;
                  wrap_nxt = 1'b1;
               end
            end else begin
               q_nxt = Q + WIDTH'(1);
            end
         end else begin
            if (Q == '0) begin
               ovf_nxt = 1'b1;
               if (SATURATE != SAT_MODE) begin
                  q_nxt    = MAX_Q;
                  wrap_nxt = 1'b1;
               end
            end else begin
               q_nxt = Q - WIDTH'(1);
            end
         end
      end
   end

   always_ff @(posedge Clk or posedge Clr) begin
      if (Clr) begin
         Q    <= '0;
         Wrap <= 1'b0;
         Ovf  <= 1'b0;
      end else begin
         Q    <= q_nxt;
         Wrap <= wrap_nxt;
         Ovf  <= ovf_nxt;
      end
   end

   assign Tc = (Up && (Q == MAX_Q)) || (!Up && (Q == '0));

endmodule : updown_counter

// File: tb/tb_updown_counter.sv
// Scoreboard bench: four counter configurations (decade wrap, decade saturate,
// 16-bit wrap, 8-bit edge-strobed) sharing one clock and clear.
module tb_updown_counter;
   import counter_pkg::*;

   logic        Clk = 1'b0;
   logic        Clr;
   logic [3:0]  en, up, ld;
   logic [3:0]  d0, d1;
   logic [15:0] d2;
   logic [7:0]  d3;
   logic [3:0]  q0, q1;
   logic [15:0] q2;
   logic [7:0]  q3;
   logic [3:0]  tc, wr, ov;

   typedef struct {
      string tag;
      int    s;
      int    q;
      bit    w;
      bit    o;
      bit    u;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   mq[3];
   bit   mo[3];
   int   maxv[4] = '{9, 9, 65535, 255};
   bit   satv[3] = '{1'b0, 1'b1, 1'b0};

   always #5 Clk = ~Clk;

   updown_counter #(.WIDTH(4), .MAX(9), .SATURATE(WRAP_MODE), .EDGE(LEVEL_EN)) u_dec (
      .Clk(Clk), .Clr(Clr), .En(en[0]), .Up(up[0]), .Load(ld[0]), .D(d0),
      .Q(q0), .Tc(tc[0]), .Wrap(wr[0]), .Ovf(ov[0]));

   updown_counter #(.WIDTH(4), .MAX(9), .SATURATE(SAT_MODE), .EDGE(LEVEL_EN)) u_sat (
      .Clk(Clk), .Clr(Clr), .En(en[1]), .Up(up[1]), .Load(ld[1]), .D(d1),
      .Q(q1), .Tc(tc[1]), .Wrap(wr[1]), .Ovf(ov[1]));

   updown_counter #(.WIDTH(16)) u_w16 (
      .Clk(Clk), .Clr(Clr), .En(en[2]), .Up(up[2]), .Load(ld[2]), .D(d2),
      .Q(q2), .Tc(tc[2]), .Wrap(wr[2]), .Ovf(ov[2]));

   updown_counter #(.WIDTH(8), .SATURATE(WRAP_MODE), .EDGE(EDGE_EN)) u_edge (
      .Clk(Clk), .Clr(Clr), .En(en[3]), .Up(up[3]), .Load(ld[3]), .D(d3),
      .Q(q3), .Tc(tc[3]), .Wrap(wr[3]), .Ovf(ov[3]));

   task automatic check(input string tag, input longint got, input longint exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic int get_q(input int s);
      case (s)
         0:       return int'(q0);
         1:       return int'(q1);
         2:       return int'(q2);
         default: return int'(q3);
      endcase
   endfunction

   task automatic sample();
      exp_t x;
      bit   etc;
      @(posedge Clk);
      #1;
      x   = sb.pop_front();
      etc = (x.u && x.q == maxv[x.s]) || (!x.u && x.q == 0);
      check({x.tag, "_q"},    get_q(x.s), x.q);
      check({x.tag, "_wrap"}, wr[x.s],    x.w);
      check({x.tag, "_ovf"},  ov[x.s],    x.o);
      check({x.tag, "_tc"},   tc[x.s],    etc);
   endtask

   // Level-enabled DUTs: reference model, drive, push, then compare.
   task automatic mstep(input string tag, input int s, input bit e, input bit u,
                        input bit l, input int dv);
      int nq;
      bit nw;
      nq = mq[s];
      nw = 1'b0;
      if (l) begin
         nq = (dv > maxv[s]) ? maxv[s] : dv;
      end else if (e) begin
         if (u) begin
            if (mq[s] == maxv[s]) begin
               mo[s] = 1'b1;
               if (!satv[s]) begin nq = 0; nw = 1'b1; end
            end else nq = mq[s] + 1;
         end else begin
            if (mq[s] == 0) begin
               mo[s] = 1'b1;
               if (!satv[s]) begin nq = maxv[s]; nw = 1'b1; end
            end else nq = mq[s] - 1;
         end
      end
      mq[s] = nq;
      @(negedge Clk);
      en[2:0] = '0;
      ld[2:0] = '0;
      en[s]   = e;
      up[s]   = u;
      ld[s]   = l;
      case (s)
         0:       d0 = 4'(dv);
         1:       d1 = 4'(dv);
         default: d2 = 16'(dv);
      endcase
      sb.push_back('{tag, s, nq, nw, mo[s], u});
      sample();
   endtask

   // Edge-strobed DUT: expected count supplied directly.
   task automatic estep(input string tag, input bit e, input int expq);
      @(negedge Clk);
      en[3] = e;
      sb.push_back('{tag, 3, expq, 1'b0, 1'b0, 1'b1});
      sample();
   endtask

   initial begin
      Clr = 1'b1;
      en  = 4'b1000;
      up  = '1;
      ld  = '0;
      d0  = '0; d1 = '0; d2 = '0; d3 = '0;
      for (int i = 0; i < 3; i++) begin mq[i] = 0; mo[i] = 1'b0; end
      repeat (2) @(negedge Clk);
      check("rst_q0", q0, 0);
      check("rst_q2", q2, 0);
      check("rst_q3", q3, 0);
      check("rst_wrap", wr, 0);
      check("rst_ovf", ov, 0);
      check("rst_tc", tc, 0);

      // Strobe already high at release must not count.
      @(negedge Clk);
      Clr = 1'b0;
      for (int k = 0; k < 6; k++) estep("edge_held", 1'b1, 0);
      for (int k = 0; k < 5; k++) estep("edge_low", 1'b0, 0);
      for (int k = 1; k <= 10; k++) estep("edge_hold10", 1'b1, (k >= 3) ? 1 : 0);
      for (int k = 0; k < 4; k++) estep("edge_low2", 1'b0, 1);
      for (int k = 1; k <= 4; k++) estep("edge_second", 1'b1, (k >= 3) ? 2 : 1);

      @(negedge Clk);
      Clr   = 1'b1;
      en[3] = 1'b0;
      #1;
      check("clr_async_q3", q3, 0);
      check("clr_async_wrap", wr[3], 0);
      @(negedge Clk);
      Clr = 1'b0;

      mstep("dec_clamp",   0, 1'b0, 1'b1, 1'b1, 12);
      mstep("dec_ld_en",   0, 1'b1, 1'b1, 1'b1, 5);
      mstep("dec_ld8",     0, 1'b0, 1'b1, 1'b1, 8);
      mstep("dec_up9",     0, 1'b1, 1'b1, 1'b0, 0);
      mstep("dec_wrap",    0, 1'b1, 1'b1, 1'b0, 0);
      check("dec_q_zero", q0, 0);
      mstep("dec_idle",    0, 1'b0, 1'b1, 1'b0, 0);
      mstep("dec_updir",   0, 1'b0, 1'b0, 1'b0, 0);
      mstep("dec_dnwrap",  0, 1'b1, 1'b0, 1'b0, 0);
      mstep("dec_dn8",     0, 1'b1, 1'b0, 1'b0, 0);
      mstep("dec_ld2",     0, 1'b0, 1'b1, 1'b1, 2);
      mstep("dec_clamp2",  0, 1'b0, 1'b1, 1'b1, 12);

      mstep("sat_dn0",     1, 1'b1, 1'b0, 1'b0, 0);
      for (int k = 0; k < 3; k++) mstep("sat_up", 1, 1'b1, 1'b1, 1'b0, 0);
      check("sat_q3", q1, 3);
      mstep("sat_ld9",     1, 1'b0, 1'b1, 1'b1, 9);
      mstep("sat_hold9",   1, 1'b1, 1'b1, 1'b0, 0);

      mstep("w16_ld",      2, 1'b0, 1'b1, 1'b1, 16'hFFFE);
      mstep("w16_max",     2, 1'b1, 1'b1, 1'b0, 0);
      mstep("w16_wrap",    2, 1'b1, 1'b1, 1'b0, 0);
      mstep("w16_dnwrap",  2, 1'b1, 1'b0, 1'b0, 0);
      check("w16_q_ffff", q2, 16'hFFFF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_updown_counter

// File: doc/updown_counter.md
UPDOWN_COUNTER -- requirements
Module: updown_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 16: counter width in bits, legal range 2..32.
REQ-002 SHALL have parameter MAX, default 2**WIDTH-1: terminal value; the count range is 0..MAX, and MAX SHALL be no more than 2**WIDTH-1.
REQ-003 SHALL have parameter SATURATE, default 0: 0 means the count wraps at the range ends, 1 means it holds at the range ends.
REQ-004 SHALL have parameter EDGE, default 0: 0 means En is a level enable, 1 means En is an asynchronous strobe that counts once per rising edge.
REQ-005 SHALL have port Clk, input, 1 bit: the single clock; all state SHALL update on posedge Clk.
REQ-006 SHALL have port Clr, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port En, input, 1 bit: count enable, interpreted as level or strobe according to EDGE.
REQ-008 SHALL have port Up, input, 1 bit: direction, 1 = count up, 0 = count down.
REQ-009 SHALL have port Load, input, 1 bit: synchronous parallel load.
REQ-010 SHALL have port D, input, WIDTH bits: load value.
REQ-011 SHALL have port Q, output, WIDTH bits: registered count.
REQ-012 SHALL have port Tc, output, 1 bit: combinational terminal count, equal to (Up & Q==MAX) | (~Up & Q==0).
REQ-013 SHALL have port Wrap, output, 1 bit: registered one-cycle pulse on wrap-around.
REQ-014 SHALL have port Ovf, output, 1 bit: registered sticky flag, set on any wrap or on any attempt to step past a range end while saturated.

Function
REQ-015 SHALL define the internal step strobe "step" as En when EDGE=0; when EDGE=1, step SHALL be the rising edge of En after a 2-flop synchroniser, high for exactly one Clk cycle.
REQ-016 SHALL apply priority Load over step; when Load=1, Q SHALL take D on the next edge, independent of step and Up.
REQ-017 SHALL clamp a Load value D > MAX so that Q becomes MAX; a clamped load SHALL set neither Wrap nor Ovf.
REQ-018 SHALL count up on step with Up=1 and Q<MAX: Q becomes Q+1, with a latency of 1 cycle after step.
REQ-019 SHALL count down on step with Up=0 and Q>0: Q becomes Q-1.
REQ-020 SHALL, with SATURATE=0, make Q wrap on step: from MAX counting up Q becomes 0; from 0 counting down Q becomes MAX; Wrap SHALL be 1 for the cycle following that edge, and Ovf SHALL be set.
REQ-021 SHALL, with SATURATE=1, hold Q at MAX when stepping up from MAX and at 0 when stepping down from 0; Wrap SHALL stay 0 and Ovf SHALL be set.
REQ-022 SHALL hold Q, keep Wrap at 0 and leave Ovf unchanged when neither step nor Load is active.
REQ-023 SHALL sample Up on the same edge as step; a change of Up with no step SHALL NOT change Q.
REQ-024 SHALL clear Ovf only through Clr; Load SHALL NOT clear Ovf.
REQ-025 SHALL handle MAX values that are not a power of two, for example MAX=9 with WIDTH=4, which gives a decade counter.

Reset
REQ-026 SHALL, while Clr=1, asynchronously force Q=0, Wrap=0, Ovf=0 and both synchroniser flops plus the edge-history flop to 0.
REQ-027 SHALL make the first step possible on the first Clk edge after Clr is released; a Clr mid-count SHALL abort the count with no Wrap pulse.
REQ-028 SHALL NOT let an En that is already high when Clr is released (with EDGE=1) produce a step until En goes low and then high again.

Structure
REQ-029 SHALL place the SATURATE and EDGE mode constants (WRAP_MODE=0, SAT_MODE=1, LEVEL_EN=0, EDGE_EN=1) in the shared package counter_pkg.
REQ-030 SHALL implement the synchroniser plus rising-edge detector as the sub-module edge_detect (ports Clk, Clr, In, Pulse), instantiated only when EDGE=1.
REQ-031 SHALL keep the count register, next-state logic and flags in updown_counter itself.

Verification
REQ-032 SHALL cover, with WIDTH=4, MAX=9, SATURATE=0: Load D=8, then 2 up steps -> Q=9 then Q=0, Wrap high for 1 cycle, Ovf=1.
REQ-033 SHALL cover, with WIDTH=4, MAX=9, SATURATE=1: Q=0, 1 down step -> Q stays 0, Wrap=0, Ovf=1; then 3 up steps -> Q=3.
REQ-034 SHALL cover, with WIDTH=16: Load D=16'hFFFE, 2 up steps -> Q=FFFF with Tc=1, then Q=0000 with Wrap pulse; Up=0 step -> Q=FFFF.
REQ-035 SHALL cover: Load=1 and En=1 on the same edge with D=5 -> Q=5 (no increment); with MAX=9, a load of D=12 -> Q=9 with Ovf unchanged.
REQ-036 SHALL cover, with EDGE=1: En held high for 10 cycles -> exactly 1 increment, occurring 3 cycles after the En rise; Clr pulse mid-count -> Q=0 at once.
